// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI subordinate backed by a word-organised memory array.
// Accepts one request per grant after a configurable grant delay, applies
// byte-enabled writes and returns read data / errors in grant order through a
// fixed-latency response pipeline with no backpressure.
// Optional feature macro: OBI_RESP_ERR_EN (out-of-range address or non-zero
// atop produces err=1, rdata=0 and suppresses the write).
module obi_mem_responder #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned GNT_WAIT = 0,
  parameter int unsigned RESP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             obi_req_i,
  output logic             obi_gnt_o,
  input  logic [WIDTH-1:0] obi_addr_i,
  input  logic             obi_we_i,
  input  logic [3:0]       obi_be_i,
  input  logic [WIDTH-1:0] obi_wdata_i,
  input  logic [5:0]       obi_atop_i,
  output logic             obi_rvalid_o,
  output logic [WIDTH-1:0] obi_rdata_o,
  output logic             obi_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (GNT_WAIT > 0) ? 4'(GNT_WAIT - 1) : 4'd0;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t           state;
  logic [3:0]       count;
  logic             gnt;
  logic             req_err;
  logic             unused_bits;
  logic [AW-1:0]    word_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             stage_valid;
  logic [WIDTH-1:0] stage_rdata;
  logic             stage_err;

  logic [RESP_LAT-1:0] pipe_valid;
  logic [RESP_LAT-1:0] pipe_err;
  logic [WIDTH-1:0]    pipe_rdata [RESP_LAT];

  assign word_idx = obi_addr_i[AW+1:2];

`ifdef OBI_RESP_ERR_EN
  logic addr_oor;
  assign addr_oor    = (obi_addr_i >> (AW + 2)) != '0;
  assign req_err     = addr_oor || (obi_atop_i != 6'd0);
  assign unused_bits = ^obi_addr_i[1:0];
`else
  assign req_err     = 1'b0;
  assign unused_bits = ^{obi_addr_i, obi_atop_i};
`endif

  // Grant decision: immediate in IDLE when there is no wait, otherwise when the
  // wait counter has run out while the request is still held; never in reset.
  always_comb begin
    gnt = 1'b0;
    if (rst_n && obi_req_i) begin
      if (state == ST_IDLE) begin
        gnt = (GNT_WAIT == 0);
      end else begin
        gnt = (count == 4'd0);
      end
    end
  end

  assign obi_gnt_o = gnt;

  // Grant-delay FSM; a request dropped during the wait abandons the transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (obi_req_i && (GNT_WAIT != 0)) begin
            state <= ST_WAIT;
            count <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!obi_req_i || (count == 4'd0)) begin
            state <= ST_IDLE;
            count <= 4'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= 4'd0;
        end
      endcase
    end
  end

  // Byte-enabled memory write at the edge closing the grant cycle; contents are never reset.
  always_ff @(posedge clk) begin
    if (gnt && obi_we_i && !req_err) begin
      for (int n = 0; n < 4; n++) begin
        if (obi_be_i[n]) begin
          mem[word_idx][8*n +: 8] <= obi_wdata_i[8*n +: 8];
        end
      end
    end
  end

  // Response captured in the grant cycle: read data comes straight from the array.
  always_comb begin
    stage_valid = gnt;
    stage_err   = gnt && req_err;
    stage_rdata = '0;
    if (gnt && !obi_we_i && !req_err) begin
      stage_rdata = mem[word_idx];
    end
  end

  // Fixed-latency response shift register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < RESP_LAT; i++) begin
        pipe_rdata[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= stage_valid;
      pipe_err[0]   <= stage_err;
      pipe_rdata[0] <= stage_rdata;
      for (int i = 1; i < RESP_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
    end
  end

  assign obi_rvalid_o = pipe_valid[RESP_LAT-1];
  assign obi_rdata_o  = pipe_rdata[RESP_LAT-1];
  assign obi_err_o    = pipe_err[RESP_LAT-1];

endmodule

// File: tb/tb_obi_mem_responder.sv
// Testbench for obi_mem_responder: two instances (no grant wait / 3-cycle wait)
// driven with directed and random OBI transactions. Expected responses come from
// a word-array memory model and are queued at grant time; a monitor pops and
// compares whenever rvalid is seen.
module tb_obi_mem_responder;

  localparam int GW0 = 0;
  localparam int RL0 = 1;
  localparam int GW1 = 3;
  localparam int RL1 = 3;

`ifdef OBI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req, we, gnt, rvalid, err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  be [2];
  logic [5:0]  atop [2];

  int          cyc = 0;
  int          vectors = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem_m [2][16];

  obi_mem_responder #(.WIDTH(32), .DEPTH(1024), .GNT_WAIT(GW0), .RESP_LAT(RL0)) dut0 (
    .clk(clk), .rst_n(rst_n), .obi_req_i(req[0]), .obi_gnt_o(gnt[0]),
    .obi_addr_i(addr[0]), .obi_we_i(we[0]), .obi_be_i(be[0]), .obi_wdata_i(wdata[0]),
    .obi_atop_i(atop[0]), .obi_rvalid_o(rvalid[0]), .obi_rdata_o(rdata[0]), .obi_err_o(err[0])
  );

  obi_mem_responder #(.WIDTH(32), .DEPTH(1024), .GNT_WAIT(GW1), .RESP_LAT(RL1)) dut1 (
    .clk(clk), .rst_n(rst_n), .obi_req_i(req[1]), .obi_gnt_o(gnt[1]),
    .obi_addr_i(addr[1]), .obi_we_i(we[1]), .obi_be_i(be[1]), .obi_wdata_i(wdata[1]),
    .obi_atop_i(atop[1]), .obi_rvalid_o(rvalid[1]), .obi_rdata_o(rdata[1]), .obi_err_o(err[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Random address inside the first 16 words, occasionally with upper bits set.
  function automatic logic [31:0] make_addr();
    logic [31:0] upper, idx, low;
    upper = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 32'hFFFFF)) : 32'd0;
    idx   = 32'($urandom_range(0, 15));
    low   = 32'($urandom_range(0, 3));
    return (upper << 12) | (idx << 2) | low;
  endfunction

  // Drive one request on port p, wait (bounded) for its grant, check grant
  // latency and push the model's expected response.
  task automatic applyStimulus(input int p, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d, input logic [5:0] at);
    int   t0, gw, rl, waited, idx;
    bit   got;
    exp_t e;
    gw = (p == 0) ? GW0 : GW1;
    rl = (p == 0) ? RL0 : RL1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d; atop[p] = at;
    t0 = cyc; got = 1'b0; waited = 0;
    while (!got) begin
      @(negedge clk);
      if (gnt[p]) begin
        got = 1'b1;
      end else begin
        waited++;
        if (waited > 20) break;
        @(posedge clk); #1;
      end
    end
    vectors++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL grant_timeout p%0d: got no gnt, expected gnt after %0d cycles", p, gw);
    end else if (cyc - t0 != gw) begin
      fails++;
      $display("[TB] FAIL grant_latency p%0d: got %0d cycles, expected %0d", p, cyc - t0, gw);
    end
    if (got) begin
      idx     = int'(a[5:2]);
      e.err   = ERR_EN && ((a[31:12] != 20'd0) || (at != 6'd0));
      e.rdata = 32'd0;
      e.due   = cyc + rl;
      if (!e.err) begin
        if (w) begin
          for (int n = 0; n < 4; n++)
            if (b[n]) mem_m[p][idx][8*n +: 8] = d[8*n +: 8];
        end else begin
          e.rdata = mem_m[p][idx];
        end
      end
      if (p == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk); #1;
    req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'd0; be[p] = 4'd0; wdata[p] = 32'd0; atop[p] = 6'd0;
  endtask

  task automatic checkOutput(input int p, input logic v, input logic [31:0] d, input logic er);
    exp_t e;
    bit   have;
    vectors++;
    if (v) begin
      have = 1'b0;
      if (p == 0) begin
        if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      end else begin
        if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      end
      if (!have) begin
        fails++;
        $display("[TB] FAIL unexpected_rvalid p%0d: got rvalid=1 rdata=%h, expected rvalid=0", p, d);
      end else if (d !== e.rdata || er !== e.err || cyc != e.due) begin
        fails++;
        $display("[TB] FAIL response p%0d: got rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                 p, d, er, cyc, e.rdata, e.err, e.due);
      end
    end else if (d !== 32'd0 || er !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_outputs p%0d: got rdata=%h err=%b, expected 0/0", p, d, er);
    end
  endtask

  // Response monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput(0, rvalid[0], rdata[0], err[0]);
      checkOutput(1, rvalid[1], rdata[1], err[1]);
    end
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'd0; be[p] = 4'd0; wdata[p] = 32'd0; atop[p] = 6'd0;
    end
    req[0] = 1'b1;
    rst_n  = 1'b0;
    @(negedge clk);
    expectEq("gnt_in_reset", 32'(gnt[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      expectEq("reset_gnt", 32'(gnt[p]), 32'd0);
      expectEq("reset_rvalid", 32'(rvalid[p]), 32'd0);
      expectEq("reset_rdata", rdata[p], 32'd0);
      expectEq("reset_err", 32'(err[p]), 32'd0);
    end
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Fill the 16 modelled words on both ports.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++)
        applyStimulus(p, 1'b1, 32'(i * 4), 4'hF, $urandom, 6'd0);

    // Back-to-back write then read, and byte-enable merge.
    applyStimulus(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 6'd0);
    applyStimulus(0, 1'b0, 32'h10, 4'hF, 32'd0, 6'd0);
    applyStimulus(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 6'd0);
    applyStimulus(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 6'd0);
    applyStimulus(0, 1'b0, 32'h20, 4'h0, 32'd0, 6'd0);

    // Out-of-range write (error or wrap depending on build), then read word 0.
    applyStimulus(0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 6'd0);
    applyStimulus(0, 1'b0, 32'h0, 4'hF, 32'd0, 6'd0);
    applyStimulus(1, 1'b1, 32'h1000, 4'hF, 32'h0BADC0DE, 6'd0);
    applyStimulus(1, 1'b0, 32'h0, 4'hF, 32'd0, 6'd0);
    applyStimulus(0, 1'b1, 32'h8, 4'hF, 32'h12345678, 6'd9);
    applyStimulus(0, 1'b0, 32'h8, 4'hF, 32'd0, 6'd0);

    // Held request on the waiting port: consecutive grants each wait the full delay.
    applyStimulus(1, 1'b1, 32'h30, 4'hF, 32'h55AA55AA, 6'd0);
    applyStimulus(1, 1'b0, 32'h30, 4'hF, 32'd0, 6'd0);

    // Protocol violation: request dropped during the wait.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'hC; be[1] = 4'hF; wdata[1] = 32'hFFFFFFFF;
    @(negedge clk);
    expectEq("violation_gnt_c0", 32'(gnt[1]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    expectEq("violation_gnt_c1", 32'(gnt[1]), 32'd0);
    @(posedge clk); #1;
    req[1] = 1'b0; we[1] = 1'b0; addr[1] = 32'd0; be[1] = 4'd0; wdata[1] = 32'd0;
    repeat (6) begin
      @(negedge clk);
      expectEq("violation_gnt_after", 32'(gnt[1]), 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 32'hC, 4'hF, 32'd0, 6'd0);

    // Random traffic on both ports.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      applyStimulus(0, 1'($urandom_range(0, 1)), make_addr(), 4'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0);
    end
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), make_addr(), 4'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0);
    end

    // Reset one cycle after a read grant with responses in flight.
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 32'h14, 4'hF, 32'd0, 6'd0);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h18; be[0] = 4'hF; wdata[0] = ~mem_m[0][6];
    @(negedge clk);
    expectEq("reset_write_gnt", 32'(gnt[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req[0] = 1'b0; we[0] = 1'b0; addr[0] = 32'd0; be[0] = 4'd0; wdata[0] = 32'd0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      expectEq("post_reset_rvalid", 32'(rvalid[p]), 32'd0);
      expectEq("post_reset_rdata", rdata[p], 32'd0);
      expectEq("post_reset_err", 32'(err[p]), 32'd0);
    end
    repeat (8) @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 32'h18, 4'hF, 32'd0, 6'd0);
    applyStimulus(1, 1'b0, 32'h14, 4'hF, 32'd0, 6'd0);

    repeat (10) @(posedge clk);
    #1;
    expectEq("q0_drained", 32'(q0.size()), 32'd0);
    expectEq("q1_drained", 32'(q1.size()), 32'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
